// File: rtl/mmio_sensor_hub.sv
// Sensor aggregation peripheral on the picorv32 native bus: live registers, a tagged sample FIFO
// fed by per-channel pending slots through a fixed-priority arbiter, and a FIFO-level interrupt.
module mmio_sensor_hub #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     hub_sel,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic                     irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 3 + DATA_W;

    logic                           ready_q, ready_d;
    logic [31:0]                    rdata_q, rdata_d;
    logic                           irq_q, irq_d;
    logic [NUM_CH-1:0]              ch_en_q, ch_en_d;
    logic                           irq_en_q, irq_en_d;
    logic [7:0]                     thresh_q, thresh_d;
    logic                           ovf_q, ovf_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  live_q, live_d;
    logic [NUM_CH-1:0]              pend_q, pend_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  pdata_q, pdata_d;
    logic [PTR_W-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [ENT_W-1:0]               fifo_q [FIFO_DEPTH];

    logic              access, rd_acc, wr_acc, empty, full, pop, push;
    logic [5:0]        word;
    logic [ENT_W-1:0]  head, push_entry;
    logic [NUM_CH-1:0] win_oh;
    logic [31:0]       ctrl_merge;
    logic              unused_bits;

    assign hub_sel   = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign irq       = irq_q;

    assign word   = mem_addr[7:2];
    assign access = hub_sel && !ready_q;
    assign rd_acc = access && (mem_wstrb == 4'h0);
    assign wr_acc = access && (mem_wstrb != 4'h0);
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign head   = fifo_q[rptr_q];
    assign pop    = rd_acc && (word == 6'h03) && !empty;
    assign push   = (pend_q != '0) && (!full || pop);

    assign unused_bits = ^{mem_addr[1:0], ctrl_merge};

    // Register read mux; evaluated on pre-update state, registered with the ready pulse.
    always_comb begin
        rdata_d = '0;
        if (rd_acc) begin
            case (word)
                6'h00: begin
                    rdata_d[NUM_CH-1:0] = ch_en_q;
                    rdata_d[16]         = irq_en_q;
                end
                6'h01: rdata_d = {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty};
                6'h02: rdata_d = {24'h0, thresh_q};
                6'h03: begin
                    if (!empty) begin
                        rdata_d = {1'b1, 4'h0, head[ENT_W-1 -: 3], 24'(head[DATA_W-1:0])};
                    end
                end
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (word == 6'(i + 4)) rdata_d = 32'(live_q[i]);
                    end
                end
            endcase
        end
    end

    // Fixed-priority arbiter: the lowest pending channel wins.
    always_comb begin
        win_oh     = '0;
        push_entry = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                push_entry = {3'(i), pdata_q[i]};
            end
        end
    end

    always_comb begin
        live_d  = live_q;
        pend_d  = pend_q;
        pdata_d = pdata_q;
        ovf_d   = ovf_q;
        if (wr_acc && (word == 6'h01) && mem_wdata[2]) ovf_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (push && win_oh[i]) pend_d[i] = 1'b0;
            if (ch_valid[i] && ch_en_q[i]) begin
                live_d[i]  = ch_data[i*DATA_W +: DATA_W];
                // A still-pending sample that did not reach the FIFO is lost.
                if (pend_d[i]) ovf_d = 1'b1;
                pend_d[i]  = 1'b1;
                pdata_d[i] = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ctrl_merge              = '0;
        ctrl_merge[NUM_CH-1:0]  = ch_en_q;
        ctrl_merge[16]          = irq_en_q;
        for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) ctrl_merge[8*b +: 8] = mem_wdata[8*b +: 8];
        end
        ch_en_d  = ch_en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (wr_acc && (word == 6'h00)) begin
            ch_en_d  = ctrl_merge[NUM_CH-1:0];
            irq_en_d = ctrl_merge[16];
        end
        if (wr_acc && (word == 6'h02) && mem_wstrb[0]) thresh_d = mem_wdata[7:0];
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = access;
        irq_d   = irq_en_d && (thresh_d != 8'h0) && (8'(count_d) >= thresh_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            ch_en_q  <= '0;
            irq_en_q <= 1'b0;
            thresh_q <= 8'd1;
            ovf_q    <= 1'b0;
            live_q   <= '0;
            pend_q   <= '0;
            pdata_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            ch_en_q  <= ch_en_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            live_q   <= live_d;
            pend_q   <= pend_d;
            pdata_q  <= pdata_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= push_entry;
    end

endmodule

// File: tb/tb_mmio_sensor_hub.sv
// Self-checking bench for mmio_sensor_hub: a queue-based behavioural model checked every cycle,
// plus directed bus transactions with hand-computed expected values.
module tb_mmio_sensor_hub;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        hub_sel, mem_ready, irq;
    logic [31:0] mem_rdata;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_sensor_hub #(
        .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .hub_sel(hub_sel),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ch_data(ch_data),
        .ch_valid(ch_valid), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO is a queue holding the exact word a POP read returns.
    logic        m_ready, m_irq, m_irq_en, m_ovf;
    logic [31:0] m_rdata;
    logic [3:0]  m_en;
    logic [7:0]  m_thresh;
    logic [31:0] m_q[$];
    logic        m_pend[NCH];
    logic [15:0] m_pdata[NCH];
    logic [15:0] m_live[NCH];
    bit          model_live = 0;

    always @(posedge clk) begin : model
        logic acc, rd, wr;
        int w, win;
        logic [31:0] rv, cur;
        logic [15:0] s;
        if (reset) begin
            m_ready = 0; m_rdata = 0; m_irq = 0; m_irq_en = 0; m_ovf = 0;
            m_en = 0; m_thresh = 8'd1; m_q.delete();
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 0; m_pdata[i] = 0; m_live[i] = 0;
            end
            model_live = 1;
        end else begin
            acc = mem_valid && (mem_addr[31:8] == BASE[31:8]) && !m_ready;
            rd  = acc && (mem_wstrb == 0);
            wr  = acc && (mem_wstrb != 0);
            w   = int'(mem_addr[7:2]);
            rv  = 0;
            if (rd) begin
                if (w == 0) rv = {15'b0, m_irq_en, 12'b0, m_en};
                else if (w == 1)
                    rv = (32'(m_q.size()) << 8) | (32'(m_ovf) << 2)
                       | (32'(m_q.size() == DEPTH) << 1) | 32'(m_q.size() == 0);
                else if (w == 2) rv = 32'(m_thresh);
                else if (w == 3) begin
                    if (m_q.size() > 0) rv = m_q.pop_front();
                end else if (w >= 4 && w < 4 + NCH) rv = 32'(m_live[w-4]);
            end
            win = -1;
            for (int i = NCH - 1; i >= 0; i--) if (m_pend[i]) win = i;
            if (win >= 0 && m_q.size() < DEPTH) begin
                m_q.push_back(32'h8000_0000 | (32'(win) << 24) | 32'(m_pdata[win]));
                m_pend[win] = 0;
            end
            if (wr && w == 1 && mem_wdata[2]) m_ovf = 0;
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i] && m_en[i]) begin
                    s = ch_data[i*DW +: DW];
                    m_live[i] = s;
                    if (m_pend[i]) m_ovf = 1;
                    m_pend[i] = 1;
                    m_pdata[i] = s;
                end
            end
            if (wr && w == 0) begin
                cur = {15'b0, m_irq_en, 12'b0, m_en};
                for (int b = 0; b < 4; b++) if (mem_wstrb[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                m_en = cur[3:0];
                m_irq_en = cur[16];
            end
            if (wr && w == 2 && mem_wstrb[0]) m_thresh = mem_wdata[7:0];
            m_irq   = m_irq_en && (m_thresh != 0) && (m_q.size() >= int'(m_thresh));
            m_ready = acc;
            m_rdata = rv;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("ready", 32'(mem_ready), 32'(m_ready));
            check("rdata", mem_rdata, m_rdata);
            check("irq", 32'(irq), 32'(m_irq));
            check("hub_sel", 32'(hub_sel), 32'(mem_valid && (mem_addr[31:8] == BASE[31:8])));
        end
    end

    // All stimulus tasks start and end 2 time units after a falling edge.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata);
        int n = 0;
        mem_valid = 1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 4);
        rdata = mem_rdata;
        check("latency", 32'(n), 32'd1);
        #2 mem_valid = 0; mem_wstrb = 0;
        @(negedge clk);
        check("ready_single_pulse", 32'(mem_ready), 32'd0);
        #2;
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        logic [31:0] r;
        bus(BASE + off, 32'h0, 4'h0, r);
        check(name, r, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        bus(addr, data, 4'hF, r);
    endtask

    task automatic strobe(input logic [NCH-1:0] mask, input logic [NCH*DW-1:0] data);
        ch_valid = mask; ch_data = data;
        @(negedge clk);
        #2 ch_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1);
    end

    initial begin
        reset = 1; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        ch_data = 0; ch_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        #2 reset = 0;
        idle(1);

        // Reset register values
        rd(32'h04, 32'h0000_0001, "status_reset");
        rd(32'h08, 32'h0000_0001, "thresh_reset");
        rd(32'h00, 32'h0000_0000, "ctrl_reset");
        rd(32'h14, 32'h0000_0000, "live1_reset");

        // Single channel capture and pop
        wr(BASE, 32'h1);
        strobe(4'b0001, 64'h1234);
        idle(2);
        rd(32'h10, 32'h0000_1234, "live0");
        rd(32'h04, 32'h0000_0100, "status_count1");
        rd(32'h0C, 32'h8000_1234, "pop_ch0");
        rd(32'h0C, 32'h0000_0000, "pop_empty");

        // All channels in one cycle: drained lowest index first
        wr(BASE, 32'hF);
        strobe(4'b1111, 64'h00A3_00A2_00A1_00A0);
        idle(5);
        rd(32'h0C, 32'h8000_00A0, "pop_arb0");
        rd(32'h0C, 32'h8100_00A1, "pop_arb1");
        rd(32'h0C, 32'h8200_00A2, "pop_arb2");
        rd(32'h0C, 32'h8300_00A3, "pop_arb3");
        rd(32'h04, 32'h0000_0001, "status_no_ovf");

        // Fill the FIFO on channel 2, then overrun the pending slot
        for (int k = 0; k < DEPTH; k++) strobe(4'b0100, 64'(k) << 32);
        strobe(4'b0100, 64'hE0 << 32);
        strobe(4'b0100, 64'hE1 << 32);
        idle(3);
        rd(32'h04, 32'h0000_1006, "status_full_ovf");
        rd(32'h18, 32'h0000_00E1, "live2");
        wr(BASE + 32'h04, 32'h4);
        rd(32'h04, 32'h0000_1002, "status_ovf_clr");
        for (int k = 0; k < DEPTH; k++) rd(32'h0C, 32'h8200_0000 | 32'(k), "pop_fill");
        rd(32'h0C, 32'h8200_00E1, "pop_pending");
        rd(32'h04, 32'h0000_0001, "status_drained");

        // Threshold interrupt
        wr(BASE + 32'h08, 32'h3);
        wr(BASE, 32'h0001_000F);
        strobe(4'b0010, 64'h1 << 16);
        strobe(4'b0010, 64'h2 << 16);
        idle(2);
        check("irq_below", 32'(irq), 32'd0);
        strobe(4'b0010, 64'h3 << 16);
        check("irq_pre", 32'(irq), 32'd0);
        idle(1);
        check("irq_rise", 32'(irq), 32'd1);
        rd(32'h0C, 32'h8100_0001, "pop_irq");
        check("irq_fall", 32'(irq), 32'd0);
        rd(32'h0C, 32'h8100_0002, "pop_irq2");
        rd(32'h0C, 32'h8100_0003, "pop_irq3");

        // Unmapped offset inside the window, then an address outside it
        wr(BASE + 32'h40, 32'hFFFF_FFFF);
        rd(32'h40, 32'h0000_0000, "unmapped");
        mem_valid = 1; mem_addr = 32'h3000_0000; mem_wstrb = 0;
        repeat (3) begin
            @(negedge clk);
            check("hub_sel_out", 32'(hub_sel), 32'd0);
            check("ready_out", 32'(mem_ready), 32'd0);
        end
        #2 mem_valid = 0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
